dm_wb_cache: RTL and testbench
==============================

Name: dm_wb_cache

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache.
- Replaces the single-cycle behavioural cache with a handshaked CPU port and a word-serial backing-memory port.
- Every miss completes the access: dirty victim write-back, then refill, then the original read or write.
- Sits between the load/store unit and main memory; saturating hit/miss counters feed performance monitoring.

Parameters:
- ADDR_W, 17, word-address width.
- DATA_W, 32, word width.
- OFFSET_W, 4, log2 words per line (16 words).
- INDEX_W, 10, log2 number of lines (1024).
- CNT_W, 16, width of hit/miss counters.
- TAG_W (derived, not overridable): ADDR_W-INDEX_W-OFFSET_W. Must be >=1, checked at elaboration.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  cache can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address: {tag, index, offset}.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  DATA_W  read data; valid with resp_valid on reads.
- mem_req  out  1  backing-memory beat request.
- mem_we  out  1  1=write beat, 0=read beat.
- mem_addr  out  ADDR_W  word address of the beat.
- mem_wdata  out  DATA_W  write-beat data.
- mem_ack  in  1  beat complete; mem_rdata valid this cycle for reads.
- mem_rdata  in  DATA_W  read-beat data.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (rst=1 at an edge):
  - All valid and dirty bits cleared; tag and data arrays not reset.
  - FSM returns to IDLE; counters cleared.
  - req_ready=0 during reset, 1 in the first cycle after.
  - resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-miss aborts immediately: mem_req drops the next cycle, no response issued, dirty data discarded.
- FSM states: IDLE, LOOKUP, WB, REFILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we/addr/wdata and go to LOOKUP.
  - req_ready=0 in every other state; one outstanding request only.
- LOOKUP:
  - Hit = valid[index] && tag[index]==req tag.
  - Hit read: resp_rdata=line word, resp_valid=1 in the cycle after LOOKUP (accept at edge N, resp_valid high during cycle N+2). Return to IDLE.
  - Hit write: word updated, dirty set, resp_valid=1 with the same timing.
  - Miss with valid&&dirty victim: go to WB. Otherwise go to REFILL.
  - Counter increments: hit_count on hit, miss_count on miss. Both saturate at all-ones.
- WB:
  - Beat counter k=0..2^OFFSET_W-1.
  - mem_req=1, mem_we=1, mem_addr={old tag, index, k}, mem_wdata=cache word k.
  - Outputs held stable until mem_ack. On ack, k increments.
  - After the last ack, clear dirty and go to REFILL. mem_req is low for at least one cycle between WB and REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, k}.
  - On mem_ack, word k = mem_rdata.
  - After the last beat: tag=req tag, valid=1, dirty=0. Go to RESP.
- RESP:
  - Completes the captured access on the new line: read returns the word, write merges req_wdata and sets dirty.
  - resp_valid=1 for one cycle, then IDLE.
- mem_ack while mem_req=0 is ignored.
- resp_rdata holds its last value when resp_valid=0. Write responses leave resp_rdata unchanged.
- Beats always go in ascending offset order 0..15. No critical-word-first ordering.
- Miss latency, zero-wait memory (ack the cycle after req):
  - Clean miss: 2+2*16 cycles.
  - Dirty miss: +2*16+1 cycles.

Test Plan:
- Reset, then read 0x00010 with memory preloaded word(a)=a → miss; 16 refill beats at 0x00010..0x0001F; resp_rdata=0x00010; miss_count=1.
- Read 0x00013 immediately after → hit; resp_valid 2 cycles after accept; rdata=0x00013; hit_count=1; no mem_req.
- Write 0xDEADBEEF to 0x00013 (hit), then read 0x04013 (same index, tag 1):
  - 16 write beats to 0x00010..0x0001F, beat 3 data 0xDEADBEEF.
  - Then refill from 0x04010.
  - rdata=0x04013.
- Write miss to clean line at 0x08020 with 0x12345678 → refill only, no WB; subsequent read returns 0x12345678, line dirty.
- Random mem_ack delays of 0-5 cycles during refill → mem_addr and mem_req held stable until each ack; final data is correct.
- Assert rst during refill beat 7 → next cycle mem_req=0, resp_valid never pulses, counters=0; re-read of the same address misses.

Source files
------------

// File: rtl/dm_wb_cache_if.sv
// dm_wb_cache_if: cache bus bundle; cpu req/resp handshake, word-serial memory beats, hit/miss counters
interface dm_wb_cache_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/dm_wb_cache.sv
// dm_wb_cache: direct-mapped write-back write-allocate cache; ports clk, rst, bus (cpu req/resp, word-serial mem beats, hit/miss counters)
module dm_wb_cache #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 10,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  dm_wb_cache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  if (TAG_W < 1) begin : g_tag_chk
    $error("dm_wb_cache: TAG_W must be >= 1");
  end
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q [0:LINES*WORDS-1];
  logic [TAG_W-1:0] tag_q [0:LINES-1];
  logic [LINES-1:0] valid_q, dirty_q;
  logic we_q, gap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OFFSET_W-1:0] k_q;
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFSET_W-1:0] off;
  logic hit, mreq, beat, last;
  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx  = addr_q[OFFSET_W +: INDEX_W];
  assign off  = addr_q[OFFSET_W-1:0];
  assign hit  = valid_q[idx] && tag_q[idx] == tag;
  // gap_q forces one idle memory cycle between the write-back and refill bursts
  assign mreq = (state_q == WB || state_q == REFILL) && !gap_q;
  assign beat = mreq && bus.mem_ack;
  assign last = beat && &k_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.req_valid ? LOOKUP : IDLE;
      LOOKUP:  state_d = hit ? IDLE : (valid_q[idx] && dirty_q[idx]) ? WB : REFILL;
      WB:      state_d = last ? REFILL : WB;
      REFILL:  state_d = last ? RESP : REFILL;
      default: state_d = IDLE;
    endcase
    bus.req_ready = state_q == IDLE && !rst;
    bus.mem_req   = mreq;
    bus.mem_we    = state_q == WB;
    bus.mem_addr  = mreq ? {state_q == WB ? tag_q[idx] : tag, idx, k_q} : '0;
    bus.mem_wdata = state_q == WB ? data_q[{idx, k_q}] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      k_q            <= '0;
      gap_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      state_q        <= state_d;
      bus.resp_valid <= 1'b0;
      gap_q          <= 1'b0;
      if (bus.req_valid && state_q == IDLE) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == LOOKUP && hit) begin
        bus.resp_valid <= 1'b1;
        if (!we_q) bus.resp_rdata <= data_q[{idx, off}];
        else dirty_q[idx] <= 1'b1;
        if (bus.hit_count != '1) bus.hit_count <= bus.hit_count + CNT_W'(1);
      end
      if (state_q == LOOKUP && !hit && bus.miss_count != '1) bus.miss_count <= bus.miss_count + CNT_W'(1);
      if (beat) k_q <= k_q + OFFSET_W'(1);
      if (last && state_q == WB) begin
        dirty_q[idx] <= 1'b0;
        gap_q        <= 1'b1;
      end
      // the original access completes on the final refill edge; the last word comes straight from memory
      if (last && state_q == REFILL) begin
        valid_q[idx]   <= 1'b1;
        dirty_q[idx]   <= we_q;
        bus.resp_valid <= 1'b1;
        if (!we_q) bus.resp_rdata <= off == k_q ? bus.mem_rdata : data_q[{idx, off}];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && we_q) data_q[{idx, off}] <= wdata_q;
    if (beat && state_q == REFILL) data_q[{idx, k_q}] <= bus.mem_rdata;
    if (last && state_q == REFILL) begin
      tag_q[idx] <= tag;
      if (we_q) data_q[{idx, off}] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_dm_wb_cache.sv
// tb_dm_wb_cache: self-checking bench for dm_wb_cache with a memory responder and a flat-memory reference model
module tb_dm_wb_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dm_wb_cache_if bus ();
  dm_wb_cache dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {logic we; logic [16:0] addr; logic [31:0] data;} beat_t;
  typedef struct {logic we; logic [16:0] addr; logic [31:0] wd; logic hit; logic [31:0] rd; int lat;} vec_t;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:131071];
  logic [31:0] view [0:131071];
  logic mv [0:1023];
  logic md [0:1023];
  logic [2:0] mt [0:1023];
  int exp_hits, exp_miss, max_dly;
  logic [31:0] last_rd;
  beat_t log_q [$];
  function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endfunction
  initial begin
    logic pend;
    int wcnt;
    beat_t cur;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    pend = 1'b0;
    wcnt = 0;
    cur = '{1'b0, 17'h0, 32'h0};
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) pend = 1'b0;
      else if (!pend) begin
        pend = 1'b1;
        wcnt = int'($urandom_range(0, max_dly));
        cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
      end else if (wcnt > 0) wcnt--;
      else begin
        chk("beat_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {cur.we, cur.addr, cur.data});
        if (cur.we) mem[cur.addr] = cur.data;
        else bus.mem_rdata = mem[cur.addr];
        log_q.push_back(cur);
        bus.mem_ack = 1'b1;
        pend = 1'b0;
      end
    end
  end
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    for (int a = 0; a < 131072; a++) view[a] = mem[a];
    exp_hits = 0;
    exp_miss = 0;
    last_rd = '0;
  endtask
  task automatic access(input logic we, input logic [16:0] a, input logic [31:0] wd, output logic dh, output int lat);
    logic [9:0] idx;
    logic [2:0] tg;
    logic eh;
    logic [15:0] h0;
    beat_t exp_q [$];
    int nmis;
    idx = a[13:4];
    tg = a[16:14];
    eh = mv[idx] && mt[idx] == tg;
    if (!eh) begin
      if (mv[idx] && md[idx])
        for (int k = 0; k < 16; k++) exp_q.push_back('{1'b1, {mt[idx], idx, 4'(k)}, view[{mt[idx], idx, 4'(k)}]});
      for (int k = 0; k < 16; k++) exp_q.push_back('{1'b0, {tg, idx, 4'(k)}, 32'h0});
    end
    log_q.delete();
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1'b1);
    h0 = bus.hit_count;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", lat < 3000, 1'b1);
    if (we) chk("wr_rdata_hold", bus.resp_rdata, last_rd);
    else begin
      chk("rdata", bus.resp_rdata, view[a]);
      last_rd = view[a];
    end
    if (eh) exp_hits++;
    else exp_miss++;
    chk("hit_count", bus.hit_count, 16'(exp_hits));
    chk("miss_count", bus.miss_count, 16'(exp_miss));
    dh = bus.hit_count != h0;
    chk("beat_count", log_q.size(), exp_q.size());
    nmis = 0;
    foreach (exp_q[i])
      if (i < log_q.size() && (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].we && log_q[i].data !== exp_q[i].data))) nmis++;
    chk("beat_content", nmis, 0);
    if (!eh) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = 1'b0;
    end
    if (we) begin
      view[a] = wd;
      md[idx] = 1'b1;
    end
    @(negedge clk);
    chk("resp_pulse", bus.resp_valid, 1'b0);
  endtask
  initial begin
    vec_t vt [8];
    logic dh;
    int lat, n;
    vt[0] = '{1'b0, 17'h00010, 32'h0, 1'b0, 32'h00010, 34};
    vt[1] = '{1'b0, 17'h00013, 32'h0, 1'b1, 32'h00013, 2};
    vt[2] = '{1'b1, 17'h00013, 32'hDEADBEEF, 1'b1, 32'h0, 2};
    vt[3] = '{1'b0, 17'h04013, 32'h0, 1'b0, 32'h04013, 67};
    vt[4] = '{1'b1, 17'h08020, 32'h12345678, 1'b0, 32'h0, 34};
    vt[5] = '{1'b0, 17'h08020, 32'h0, 1'b1, 32'h12345678, 2};
    vt[6] = '{1'b0, 17'h00013, 32'h0, 1'b0, 32'hDEADBEEF, 34};
    vt[7] = '{1'b0, 17'h04015, 32'h0, 1'b0, 32'h04015, 34};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    max_dly = 0;
    for (int a = 0; a < 131072; a++) mem[a] = 32'(a);
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 17'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_hit_count", bus.hit_count, 16'h0);
    chk("rst_miss_count", bus.miss_count, 16'h0);
    rst = 1'b0;
    foreach (vt[i]) begin
      access(vt[i].we, vt[i].addr, vt[i].wd, dh, lat);
      chk($sformatf("vec%0d_hit", i), dh, vt[i].hit);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), bus.resp_rdata, vt[i].rd);
    end
    log_q.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 17'h0C050;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (log_q.size() < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_beat7", log_q.size(), 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_resp_valid", bus.resp_valid, 1'b0);
    chk("abort_hit_count", bus.hit_count, 16'h0);
    chk("abort_miss_count", bus.miss_count, 16'h0);
    chk("abort_req_ready_in_rst", bus.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_req) n++;
    end
    chk("abort_quiet", n, 0);
    model_reset();
    access(1'b0, 17'h0C050, 32'h0, dh, lat);
    chk("reread_hit", dh, 1'b0);
    chk("reread_latency", lat, 34);
    max_dly = 5;
    repeat (60) begin
      logic [16:0] a;
      a = {3'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 4'($urandom)};
      access(1'($urandom_range(0, 1)), a, $urandom, dh, lat);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
